// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO, tracks E0/F0 prefixes, suppresses typematic repeats.
// Optional ASCII lookup is compiled in when PS2_ASCII_EN is defined; otherwise key_ascii is tied to 00h.
module ps2_key_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  output logic       kb_nextdata_n,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic [7:0] key_ascii,
  output logic       shift_held,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

  state_t     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       extF_q, extF_d, brkF_q, brkF_d;
  logic [8:0] held_q, held_d;
  logic       heldV_q, heldV_d;
  logic       shiftL_q, shiftL_d, shiftR_q, shiftR_d;
  logic       valid_q, valid_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d, make_q, make_d;
  logic [7:0] count_q, count_d;

  logic       candMake, isDiscard, isRepeat;
  logic [8:0] candKey;

  assign candMake  = ~brkF_q;
  assign candKey   = {extF_q, byte_q};
  assign isRepeat  = candMake & heldV_q & (held_q == candKey);
  assign isDiscard = (byte_q == 8'h00) || (byte_q == 8'hFF) || (byte_q == 8'hAA) ||
                     (byte_q == 8'hFA) || (byte_q == 8'hEE) || (byte_q == 8'hFE);

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    extF_d        = extF_q;
    brkF_d        = brkF_q;
    held_d        = held_q;
    heldV_d       = heldV_q;
    shiftL_d      = shiftL_q;
    shiftR_d      = shiftR_q;
    valid_d       = 1'b0;
    code_d        = code_q;
    ext_d         = ext_q;
    make_d        = make_q;
    count_d       = count_q;
    kb_nextdata_n = 1'b1;
    case (state_q)
      IDLE: begin
        if (kb_ready) begin
          byte_d        = kb_data;
          kb_nextdata_n = 1'b0;
          state_d       = POP;
        end
      end
      POP: state_d = DECODE;
      DECODE: begin
        state_d = IDLE;
        if (byte_q == 8'hE0) begin
          extF_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brkF_d = 1'b1;
        end else begin
          extF_d = 1'b0;
          brkF_d = 1'b0;
          if (!isDiscard) begin
            // Shift state follows every candidate, even a suppressed repeat
            if (!extF_q && byte_q == 8'h12) shiftL_d = candMake;
            if (!extF_q && byte_q == 8'h59) shiftR_d = candMake;
            if (!isRepeat) begin
              valid_d = 1'b1;
              code_d  = byte_q;
              ext_d   = extF_q;
              make_d  = candMake;
              if (candMake) begin
                held_d  = candKey;
                heldV_d = 1'b1;
                count_d = count_q + 8'd1;
              end else if (held_q == candKey) begin
                heldV_d = 1'b0;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) kb_nextdata_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      byte_q   <= 8'h00;
      extF_q   <= 1'b0;
      brkF_q   <= 1'b0;
      held_q   <= 9'h000;
      heldV_q  <= 1'b0;
      shiftL_q <= 1'b0;
      shiftR_q <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= 8'h00;
      ext_q    <= 1'b0;
      make_q   <= 1'b0;
      count_q  <= 8'h00;
    end else begin
      state_q  <= state_d;
      byte_q   <= byte_d;
      extF_q   <= extF_d;
      brkF_q   <= brkF_d;
      held_q   <= held_d;
      heldV_q  <= heldV_d;
      shiftL_q <= shiftL_d;
      shiftR_q <= shiftR_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
      ext_q    <= ext_d;
      make_q   <= make_d;
      count_q  <= count_d;
    end
  end

  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_ext     = ext_q;
  assign key_make    = make_q;
  assign shift_held  = shiftL_q | shiftR_q;
  assign press_count = count_q;

`ifdef PS2_ASCII_EN
  logic [7:0] ascii_q, asciiNext;

  function automatic logic [7:0] asciiOf(input logic [7:0] code, input logic upper);
    logic [7:0] c;
    case (code)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: c = "0";  8'h16: c = "1";  8'h1E: c = "2";  8'h26: c = "3";
      8'h25: c = "4";  8'h2E: c = "5";  8'h36: c = "6";  8'h3D: c = "7";
      8'h3E: c = "8";  8'h46: c = "9";
      8'h29: c = 8'h20;
      8'h5A: c = 8'h0D;
      8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (upper && c >= "a" && c <= "z") c = c - 8'h20;
    return c;
  endfunction

  always_comb begin
    asciiNext = 8'h00;
    if (!extF_q) asciiNext = asciiOf(byte_q, shift_held);
  end

  // Ascii is captured alongside the other event fields so it holds until the next event
  always_ff @(posedge clk) begin
    if (rst)          ascii_q <= 8'h00;
    else if (valid_d) ascii_q <= asciiNext;
  end

  assign key_ascii = ascii_q;
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a modelled receiver FIFO feeds directed byte streams,
// expected events are queued up front and a negedge monitor compares each key_valid pulse.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_nextdata_n, key_valid, key_ext, key_make, shift_held;
  logic [7:0] key_code, key_ascii, press_count;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic [7:0] ascii;
    logic       shift;
    logic [7:0] count;
  } ev_t;

  ev_t        expQ[$];
  logic [7:0] fifo[$];
  int vectors = 0, miscompares = 0;
  int cycle = 0, pushed = 0, popped = 0, lastPop = -1, expCount = 0;
  bit popFlag = 1'b0, spacingOn = 1'b0;

  ps2_key_decoder dut (
    .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_nextdata_n(kb_nextdata_n), .key_valid(key_valid), .key_code(key_code),
    .key_ext(key_ext), .key_make(key_make), .key_ascii(key_ascii),
    .shift_held(shift_held), .press_count(press_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [7:0] ea(input logic [7:0] v);
`ifdef PS2_ASCII_EN
    return v;
`else
    return 8'h00;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo.push_back(b);
    pushed++;
  endtask

  task automatic expectEvent(input logic [7:0] code, input logic ext, input logic make,
                             input logic [7:0] ascii, input logic shift);
    ev_t e;
    if (make) expCount = (expCount + 1) % 256;
    e.code = code; e.ext = ext; e.make = make; e.ascii = ea(ascii);
    e.shift = shift; e.count = 8'(expCount);
    expQ.push_back(e);
  endtask

  task automatic checkResetState();
    checkOutput("rst_nextdata_n", kb_nextdata_n, 1);
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_key_code", key_code, 0);
    checkOutput("rst_key_ext", key_ext, 0);
    checkOutput("rst_key_make", key_make, 0);
    checkOutput("rst_key_ascii", key_ascii, 0);
    checkOutput("rst_shift_held", shift_held, 0);
    checkOutput("rst_press_count", press_count, 0);
  endtask

  task automatic applyReset();
    @(negedge clk) rst = 1'b1;
    expCount = 0;
    lastPop = -1;
    @(negedge clk) checkResetState();
    rst = 1'b0;
  endtask

  // Wait until every pushed byte is popped and decoded, then check nothing is outstanding
  task automatic drain(input int bound);
    int n = 0;
    while ((fifo.size() > 0 || popped < pushed) && n < bound) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("drain_in_time", n < bound, 1);
    checkOutput("pops_vs_bytes", popped, pushed);
    checkOutput("events_pending", expQ.size(), 0);
  endtask

  // Receiver FIFO model: head byte presented after each edge, popped after a low kb_nextdata_n
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (popFlag && fifo.size() > 0) void'(fifo.pop_front());
      popFlag  = 1'b0;
      kb_ready = (fifo.size() > 0);
      kb_data  = kb_ready ? fifo[0] : 8'h00;
    end
  end

  always @(negedge clk) begin
    if (!kb_nextdata_n) begin
      popFlag = 1'b1;
      popped++;
      checkOutput("pop_needs_ready", kb_ready, 1);
      if (spacingOn && lastPop >= 0) checkOutput("pop_spacing", cycle - lastPop, 3);
      lastPop = cycle;
    end
  end

  always @(negedge clk) begin
    if (key_valid) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got code=%0h ext=%0b make=%0b expected none",
                 key_code, key_ext, key_make);
      end else begin
        ev_t e;
        e = expQ.pop_front();
        checkOutput("ev_code", key_code, e.code);
        checkOutput("ev_ext", key_ext, e.ext);
        checkOutput("ev_make", key_make, e.make);
        checkOutput("ev_ascii", key_ascii, e.ascii);
        checkOutput("ev_shift", shift_held, e.shift);
        checkOutput("ev_count", press_count, e.count);
      end
    end
  end

  initial begin
    // Byte waiting in the FIFO during reset must not be popped
    applyStimulus(8'h1C);
    repeat (3) @(negedge clk);
    checkOutput("rst_ready_seen", kb_ready, 1);
    checkResetState();
    checkOutput("rst_no_pop", popped, 0);
    expectEvent(8'h1C, 0, 1, 8'h61, 0);
    rst = 1'b0;
    drain(100);

    applyReset();
    expectEvent(8'h1C, 0, 1, 8'h61, 0);
    expectEvent(8'h1C, 0, 0, 8'h61, 0);
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    drain(200);
    checkOutput("typematic_count", press_count, 1);

    applyReset();
    expectEvent(8'h75, 1, 1, 8'h00, 0);
    expectEvent(8'h75, 1, 0, 8'h00, 0);
    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    drain(200);

    applyReset();
    expectEvent(8'h12, 0, 1, 8'h00, 1);
    expectEvent(8'h1C, 0, 1, 8'h41, 1);
    expectEvent(8'h12, 0, 0, 8'h00, 0);
    applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h12);
    drain(200);
    checkOutput("shift_released", shift_held, 0);

    applyReset();
    expectEvent(8'h12, 0, 1, 8'h00, 1);
    expectEvent(8'h59, 0, 1, 8'h00, 1);
    expectEvent(8'h12, 0, 0, 8'h00, 1);
    expectEvent(8'h1A, 0, 1, 8'h5A, 1);
    expectEvent(8'h59, 0, 0, 8'h00, 0);
    expectEvent(8'h1A, 0, 0, 8'h7A, 0);
    applyStimulus(8'h12); applyStimulus(8'h59); applyStimulus(8'hF0); applyStimulus(8'h12);
    applyStimulus(8'h1A); applyStimulus(8'hF0); applyStimulus(8'h59);
    applyStimulus(8'h1A); applyStimulus(8'hF0); applyStimulus(8'h1A);
    drain(300);

    // Partial E0 sequence abandoned by reset
    applyReset();
    applyStimulus(8'hE0);
    drain(100);
    applyReset();
    expectEvent(8'h1C, 0, 1, 8'h61, 0);
    applyStimulus(8'h1C);
    drain(100);

    applyReset();
    applyStimulus(8'hAA);
    drain(100);
    checkOutput("aa_no_event", key_valid | key_make | (press_count != 0), 0);
    applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'hFA);
    applyStimulus(8'hEE); applyStimulus(8'hFE);
    drain(200);
    expectEvent(8'h1C, 0, 1, 8'h61, 0);
    expectEvent(8'h32, 0, 1, 8'h62, 0);
    expectEvent(8'h45, 0, 1, 8'h30, 0);
    expectEvent(8'h5A, 1, 1, 8'h00, 0);
    expectEvent(8'h5A, 0, 1, 8'h0D, 0);
    expectEvent(8'h29, 0, 1, 8'h20, 0);
    expectEvent(8'h66, 0, 1, 8'h08, 0);
    applyStimulus(8'hE0); applyStimulus(8'hAA); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'hAA); applyStimulus(8'h32);
    applyStimulus(8'h45); applyStimulus(8'hE0); applyStimulus(8'h5A);
    applyStimulus(8'h5A); applyStimulus(8'h29); applyStimulus(8'h66);
    drain(300);

    // 256 press/release pairs queued back to back: wrap of press_count and 3-cycle pop spacing
    applyReset();
    spacingOn = 1'b1;
    lastPop = -1;
    for (int i = 0; i < 256; i++) begin
      expectEvent(8'h1D, 0, 1, 8'h77, 0);
      expectEvent(8'h1D, 0, 0, 8'h77, 0);
      applyStimulus(8'h1D); applyStimulus(8'hF0); applyStimulus(8'h1D);
    end
    drain(4000);
    spacingOn = 1'b0;
    checkOutput("count_wrap", press_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
